data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Data RAM for the single-cycle 54-instruction MIPS CPU. Serves LW/SW, LB/LBU/LH/LHU and SB/SH.
//  Reads are combinational; writes are synchronous. Byte/halfword selection is little-endian.
//  Sits between the ALU address result and the register-file write-back mux.
// PARAMETERS
//  DEPTH   1024           number of 32-bit words; power of two
//  AW      $clog2(DEPTH)  word-index width (derived localparam)
//  BASE    32'h10010000   data-segment base address; used only by DMEM_ADDR_CHECK_EN
// PORTS
//  clk         in   1   clock; writes and reset act on the rising edge
//  rst_n       in   1   reset, synchronous, active-low
//  d_ram_rena  in   1   read enable
//  d_ram_wena  in   1   write enable
//  DAddr       in   32  byte address
//  DataIn      in   32  store data
//  choice      in   6   one-hot access type: [5]LB [4]LBU [3]LH [2]LHU [1]SB [0]SH; 0 = word
//  Data_out    out  32  load data, combinational
//  addr_err    out  1   only when DMEM_ADDR_CHECK_EN is defined
// BEHAVIOUR
//  - Word index = DAddr[AW+1:2]; byte offset = DAddr[1:0]. Bits above AW+1 are ignored, so BASE+8 aliases 8.
//  - Reset: rst_n=0 at a rising edge clears every word to 0. Reset has priority over a write in the same cycle.
//  - While rst_n=0, Data_out=0.
//  - Read path (combinational): if d_ram_rena=0, Data_out=0. Otherwise the value depends on choice:
//      word (choice=0 or a store bit): mem[idx]; DAddr[1:0] ignored (no alignment trap).
//      LB:  sign-extend byte at DAddr[1:0] (offset 0 = bits[7:0]).
//      LBU: zero-extend the same byte.
//      LH:  sign-extend halfword selected by DAddr[1] (0 = bits[15:0]); DAddr[0] ignored.
//      LHU: zero-extend the same halfword.
//  - Write path (rising edge, d_ram_wena=1, rst_n=1):
//      SB: DataIn[7:0] into the selected byte; other bytes unchanged.
//      SH: DataIn[15:0] into the selected half; other half unchanged.
//      Anything else (incl. load bits or choice=0): full word DataIn.
//  - Multiple choice bits set: priority LB>LBU>LH>LHU>SB>SH. The winning bit alone decides the access.
//  - rena=1 and wena=1 together: Data_out shows the pre-write contents until the edge, then the new value
//    (read-before-write, no bypass).
//  - Latency: load data is valid in the same cycle; a store is visible after the next rising edge.
// CONFIGURATION
//  DMEM_ADDR_CHECK_EN defined:
//    - Legal addresses are [0, DEPTH*4) and [BASE, BASE+DEPTH*4).
//    - For any other address: addr_err=1 (combinational), the write is suppressed, Data_out=0.
//    - Also flags a misaligned access: LH/LHU/SH with DAddr[0]=1, or word access with DAddr[1:0]!=0.
//      A misaligned access is flagged but still performed.
//  Undefined: no addr_err port; upper address bits alias freely.
// TESTING
//  1. Reset, then rena=1, DAddr=4 -> Data_out=0.
//  2. wena=1, DAddr=0x10010008, DataIn=123456, choice=0; then rena=1 at 0x10010008 and at 0x8
//     -> both 0x0001E240.
//  3. wena=1, DAddr=0, DataIn=12345; then rena=0 -> Data_out=0; rena=1 -> 0x00003039.
//  4. Word 0x10010000 cleared. SB with DataIn=0xFFFF at 0x10010000 -> word=0x000000FF;
//     LB -> 0xFFFFFFFF; LBU -> 0x000000FF.
//  5. SH with DataIn=0x8001 at 0x10010002 -> word=0x800100FF; LH -> 0xFFFF8001; LHU -> 0x00008001;
//     LB at 0x10010003 -> 0xFFFFFF80.
//  6. rena=wena=1 at DAddr=0, DataIn=7 -> 0x3039 before the edge, 7 after;
//     rst_n=0 for one edge -> reading 0 gives 0.

Source files
------------

// File: rtl/data_mem_if.sv
// Data-memory access bundle between the CPU datapath (master) and data_mem (slave).
// addr_err exists only when DMEM_ADDR_CHECK_EN is defined.
interface data_mem_if;
  logic        d_ram_rena;
  logic        d_ram_wena;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [5:0]  choice;
  logic [31:0] Data_out;
`ifdef DMEM_ADDR_CHECK_EN
  logic        addr_err;

  modport master (
    output d_ram_rena, d_ram_wena, DAddr, DataIn, choice,
    input  Data_out, addr_err
  );
  modport slave (
    input  d_ram_rena, d_ram_wena, DAddr, DataIn, choice,
    output Data_out, addr_err
  );
`else
  modport master (
    output d_ram_rena, d_ram_wena, DAddr, DataIn, choice,
    input  Data_out
  );
  modport slave (
    input  d_ram_rena, d_ram_wena, DAddr, DataIn, choice,
    output Data_out
  );
`endif
endinterface

// File: rtl/data_mem.sv
// MIPS data RAM: combinational little-endian byte/half/word reads, synchronous writes.
// Optional DMEM_ADDR_CHECK_EN adds range/alignment checking on addr_err.
module data_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h10010000
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ACC_WORD, ACC_LB, ACC_LBU, ACC_LH, ACC_LHU, ACC_SB, ACC_SH
  } acc_e;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   wr_word_d;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  acc_e          acc;
  logic          addr_ok;
  logic          unused_cfg;

  assign idx     = bus.DAddr[AW+1:2];
  assign off     = bus.DAddr[1:0];
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = rd_word[{off[1], 4'b0000} +: 16];

  // Priority decode of the one-hot access type; lowest-priority fallback is a word access.
  always_comb begin
    acc = ACC_WORD;
    if      (bus.choice[5]) acc = ACC_LB;
    else if (bus.choice[4]) acc = ACC_LBU;
    else if (bus.choice[3]) acc = ACC_LH;
    else if (bus.choice[2]) acc = ACC_LHU;
    else if (bus.choice[1]) acc = ACC_SB;
    else if (bus.choice[0]) acc = ACC_SH;
  end

`ifdef DMEM_ADDR_CHECK_EN
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [32:0] BASE_END = {1'b0, BASE} + SPAN;
  logic [32:0] addr_ext;
  logic        misaligned;

  assign addr_ext   = {1'b0, bus.DAddr};
  assign addr_ok    = (addr_ext < SPAN) || ((addr_ext >= {1'b0, BASE}) && (addr_ext < BASE_END));
  // Misaligned accesses are only flagged; they still execute.
  assign misaligned = (((acc == ACC_LH) || (acc == ACC_LHU) || (acc == ACC_SH)) && off[0])
                   || ((acc == ACC_WORD) && (off != 2'b00));
  assign bus.addr_err = !addr_ok || misaligned;
`else
  assign addr_ok = 1'b1;
`endif

  assign unused_cfg = ^{bus.DAddr[31:AW+2], BASE};

  always_comb begin
    bus.Data_out = '0;
    if (rst_n && bus.d_ram_rena && addr_ok) begin
      unique case (acc)
        ACC_LB:  bus.Data_out = {{24{rd_byte[7]}}, rd_byte};
        ACC_LBU: bus.Data_out = {24'h000000, rd_byte};
        ACC_LH:  bus.Data_out = {{16{rd_half[15]}}, rd_half};
        ACC_LHU: bus.Data_out = {16'h0000, rd_half};
        default: bus.Data_out = rd_word;
      endcase
    end
  end

  // Merge store data into the current word for partial stores.
  always_comb begin
    wr_word_d = bus.DataIn;
    if (acc == ACC_SB) begin
      wr_word_d = rd_word;
      wr_word_d[{off, 3'b000} +: 8] = bus.DataIn[7:0];
    end else if (acc == ACC_SH) begin
      wr_word_d = rd_word;
      wr_word_d[{off[1], 4'b0000} +: 16] = bus.DataIn[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.d_ram_wena && addr_ok) begin
      mem_q[idx] <= wr_word_d;
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Scoreboarded bench for data_mem: directed spec scenarios plus random traffic
// against an array-based reference memory.
module tb_data_mem;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h10010000;

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chk_en;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [DEPTH];
  exp_t        exp_q [$];

  data_mem_if bus ();

  data_mem #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_legal(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    longint unsigned x = longint'(a);
    return (x < DEPTH * 4) || (x >= longint'(BASE) && x < longint'(BASE) + DEPTH * 4);
`else
    return a == a;
`endif
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [5:0] ch);
    bit half_acc = !ch[5] && !ch[4] && (ch[3] || ch[2] || (!ch[1] && ch[0]));
    bit word_acc = (ch == 6'd0);
    return !m_legal(a) || (half_acc && (a % 2 != 0)) || (word_acc && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] m_read(input logic re, input logic [31:0] a, input logic [5:0] ch);
    logic [31:0] w = model[(a / 4) % DEPTH];
    logic [7:0]  b = 8'(w >> (8 * (a % 4)));
    logic [15:0] h = 16'(w >> (16 * ((a / 2) % 2)));
    if (!rst_n || !re || !m_legal(a)) return 32'd0;
    if (ch[5]) return 32'($signed(b));
    if (ch[4]) return {24'd0, b};
    if (ch[3]) return 32'($signed(h));
    if (ch[2]) return {16'd0, h};
    return w;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [5:0] ch);
    int unsigned i = (a / 4) % DEPTH;
    int unsigned sh;
    logic [31:0] mask;
    if (!m_legal(a)) return;
    if (ch[5:2] == 4'd0 && ch[1]) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
    end else if (ch[5:1] == 5'd0 && ch[0]) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    model[i] = (model[i] & ~mask) | ((d << sh) & mask);
  endfunction

  // One bus cycle: drive, queue the expectation, then clock and update the model.
  task automatic cyc(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [5:0] ch, input bit use_c, input logic [31:0] cval, input string nm);
    exp_t e;
    bus.d_ram_rena = re;
    bus.d_ram_wena = we;
    bus.DAddr      = a;
    bus.DataIn     = d;
    bus.choice     = ch;
    e.nm   = nm;
    e.data = use_c ? cval : m_read(re, a, ch);
    e.err  = m_err(a, ch);
    exp_q.push_back(e);
    chk_en = 1'b1;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'd0;
    end else if (we) begin
      m_write(a, d, ch);
    end
    #1;
    chk_en = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the driver marks a sampled cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: output seen with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if (bus.Data_out !== e.data) begin
            errors++;
            $display("FAIL %s: Data_out=%h expected %h (addr=%h choice=%b)",
                     e.nm, bus.Data_out, e.data, bus.DAddr, bus.choice);
          end
`ifdef DMEM_ADDR_CHECK_EN
          checks++;
          if (bus.addr_err !== e.err) begin
            errors++;
            $display("FAIL %s_err: addr_err=%b expected %b", e.nm, bus.addr_err, e.err);
          end
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic [5:0]  ch;
    int          wait_cnt;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    bus.d_ram_rena = 1'b0;
    bus.d_ram_wena = 1'b0;
    bus.DAddr = '0;
    bus.DataIn = '0;
    bus.choice = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = $urandom;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 6'd0, 1'b1, 32'h0, "in_reset_read");
    rst_n = 1'b1;

    cyc(1'b1, 1'b0, 32'h4, 32'h0, 6'd0, 1'b1, 32'h0, "reset_word4");
    cyc(1'b0, 1'b1, BASE + 32'h8, 32'd123456, 6'd0, 1'b1, 32'h0, "wr_alias");
    cyc(1'b1, 1'b0, BASE + 32'h8, 32'h0, 6'd0, 1'b1, 32'h0001_E240, "rd_base8");
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 6'd0, 1'b1, 32'h0001_E240, "rd_alias8");
    cyc(1'b0, 1'b1, 32'h0, 32'd12345, 6'd0, 1'b1, 32'h0, "wr_w0");
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 32'h0, "rena_off");
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 32'h0000_3039, "rd_w0");
    cyc(1'b1, 1'b1, 32'h0, 32'd7, 6'd0, 1'b1, 32'h0000_3039, "rbw_before");
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 32'h7, "rbw_after");

    cyc(1'b0, 1'b1, BASE, 32'h0, 6'd0, 1'b1, 32'h0, "clear_w0");
    cyc(1'b0, 1'b1, BASE, 32'hFFFF, 6'b000010, 1'b1, 32'h0, "sb");
    cyc(1'b1, 1'b0, BASE, 32'h0, 6'd0, 1'b1, 32'h0000_00FF, "sb_word");
    cyc(1'b1, 1'b0, BASE, 32'h0, 6'b100000, 1'b1, 32'hFFFF_FFFF, "lb");
    cyc(1'b1, 1'b0, BASE, 32'h0, 6'b010000, 1'b1, 32'h0000_00FF, "lbu");
    cyc(1'b0, 1'b1, BASE + 32'h2, 32'h8001, 6'b000001, 1'b1, 32'h0, "sh");
    cyc(1'b1, 1'b0, BASE, 32'h0, 6'd0, 1'b1, 32'h8001_00FF, "sh_word");
    cyc(1'b1, 1'b0, BASE + 32'h2, 32'h0, 6'b001000, 1'b1, 32'hFFFF_8001, "lh");
    cyc(1'b1, 1'b0, BASE + 32'h2, 32'h0, 6'b000100, 1'b1, 32'h0000_8001, "lhu");
    cyc(1'b1, 1'b0, BASE + 32'h3, 32'h0, 6'b100000, 1'b1, 32'hFFFF_FF80, "lb_b3");
    cyc(1'b1, 1'b0, BASE + 32'h3, 32'h0, 6'b111111, 1'b1, 32'hFFFF_FF80, "prio_lb");
    cyc(1'b1, 1'b0, BASE + 32'h1, 32'h0, 6'b001100, 1'b1, 32'h0000_00FF, "lh_a0_ign");

    for (int n = 0; n < 400; n++) begin
      a = 32'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a + BASE;
`ifdef DMEM_ADDR_CHECK_EN
      if ($urandom_range(0, 9) == 0) a = $urandom;
`endif
      case ($urandom_range(0, 3))
        0:       ch = 6'd0;
        1:       ch = 6'(1 << $urandom_range(0, 5));
        2:       ch = 6'($urandom);
        default: ch = 6'(1 << $urandom_range(0, 1));
      endcase
      d = $urandom;
      cyc(1'($urandom), 1'($urandom), a, d, ch, 1'b0, 32'h0, "random");
    end

    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 32'h0, "rst_read");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 32'h0, "post_rst_w0");
    cyc(1'b1, 1'b0, BASE + 32'h3, 32'h0, 6'b010000, 1'b1, 32'h0, "post_rst_b3");

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
